// File: rtl/rs_alu.sv
// Arithmetic reservation station: holds waiting ALU ops, wakes operands from the CDBs,
// issues the lowest-index ready entry to the combinational EX unit and registers its result.
module rs_alu #(
   parameter int RS_SIZE  = 8,
   parameter int RS_BITS  = 3,
   parameter int ROB_BITS = 4
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                clear_in,
   input  logic                disp_valid,
   input  logic [5:0]          disp_order,
   input  logic [31:0]         disp_vj,
   input  logic                disp_qj_busy,
   input  logic [ROB_BITS-1:0] disp_qj,
   input  logic [31:0]         disp_vk,
   input  logic                disp_qk_busy,
   input  logic [ROB_BITS-1:0] disp_qk,
   input  logic [31:0]         disp_A,
   input  logic [31:0]         disp_pc,
   input  logic [ROB_BITS-1:0] disp_tag,
   output logic                full,
   input  logic                lsb_cdb_valid,
   input  logic [ROB_BITS-1:0] lsb_cdb_tag,
   input  logic [31:0]         lsb_cdb_value,
   output logic [5:0]          ex_order,
   output logic [31:0]         ex_vj,
   output logic [31:0]         ex_vk,
   output logic [31:0]         ex_A,
   output logic [31:0]         ex_pc,
   input  logic [31:0]         ex_value,
   input  logic [31:0]         ex_topc,
   output logic                cdb_valid,
   output logic [ROB_BITS-1:0] cdb_tag,
   output logic [31:0]         cdb_value,
   output logic [31:0]         cdb_topc
);

   typedef struct packed {
      logic [5:0]          order;
      logic [31:0]         vj;
      logic                qj_busy;
      logic [ROB_BITS-1:0] qj;
      logic [31:0]         vk;
      logic                qk_busy;
      logic [ROB_BITS-1:0] qk;
      logic [31:0]         a;
      logic [31:0]         pc;
      logic [ROB_BITS-1:0] tag;
   } entry_t;

   logic [RS_SIZE-1:0]  busy_q, busy_d;
   entry_t              ent_q [RS_SIZE];
   entry_t              ent_d [RS_SIZE];
   logic                cdb_valid_q, cdb_valid_d;
   logic [ROB_BITS-1:0] cdb_tag_q, cdb_tag_d;
   logic [31:0]         cdb_value_q, cdb_value_d;
   logic [31:0]         cdb_topc_q, cdb_topc_d;

   logic                win_valid;
   logic [RS_BITS-1:0]  win_idx;
   logic [RS_BITS-1:0]  free_idx;

   // Returns {still_pending, value}; the LSB bus wins when both buses carry the tag.
   function automatic logic [32:0] wake(input logic q_busy, input logic [ROB_BITS-1:0] q,
                                        input logic [31:0] v);
      if (q_busy && lsb_cdb_valid && lsb_cdb_tag == q)
         wake = {1'b0, lsb_cdb_value};
      else if (q_busy && cdb_valid_q && cdb_tag_q == q)
         wake = {1'b0, cdb_value_q};
      else
         wake = {q_busy, v};
   endfunction

   assign full = &busy_q;

   // Descending scan so the lowest matching index is the last one written.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      free_idx  = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (busy_q[i] && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
            win_valid = 1'b1;
            win_idx   = RS_BITS'(i);
         end
         if (!busy_q[i])
            free_idx = RS_BITS'(i);
      end
   end

   assign ex_order = win_valid ? ent_q[win_idx].order : '0;
   assign ex_vj    = win_valid ? ent_q[win_idx].vj    : '0;
   assign ex_vk    = win_valid ? ent_q[win_idx].vk    : '0;
   assign ex_A     = win_valid ? ent_q[win_idx].a     : '0;
   assign ex_pc    = win_valid ? ent_q[win_idx].pc    : '0;

   // NOTE: combinational next-state uses blocking assignments with every output defaulted
   // first, so later statements (issue, dispatch) override earlier ones and no latch is inferred.
   always_comb begin
      busy_d      = busy_q;
      ent_d       = ent_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_value_d = cdb_value_q;
      cdb_topc_d  = cdb_topc_q;

      for (int i = 0; i < RS_SIZE; i++) begin
         if (busy_q[i]) begin
            {ent_d[i].qj_busy, ent_d[i].vj} = wake(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj);
            {ent_d[i].qk_busy, ent_d[i].vk} = wake(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk);
         end
      end

      if (win_valid) begin
         busy_d[win_idx] = 1'b0;
         cdb_valid_d     = 1'b1;
         cdb_tag_d       = ent_q[win_idx].tag;
         cdb_value_d     = ex_value;
         cdb_topc_d      = ex_topc;
      end

      // Slot choice uses registered busy bits, so an issuing entry's slot is not reused this cycle.
      if (disp_valid && !full) begin
         busy_d[free_idx]       = 1'b1;
         ent_d[free_idx].order  = disp_order;
         ent_d[free_idx].qj     = disp_qj;
         ent_d[free_idx].qk     = disp_qk;
         ent_d[free_idx].a      = disp_A;
         ent_d[free_idx].pc     = disp_pc;
         ent_d[free_idx].tag    = disp_tag;
         {ent_d[free_idx].qj_busy, ent_d[free_idx].vj} = wake(disp_qj_busy, disp_qj, disp_vj);
         {ent_d[free_idx].qk_busy, ent_d[free_idx].vk} = wake(disp_qk_busy, disp_qk, disp_vk);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         busy_q      <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
         cdb_topc_q  <= '0;
      end else if (clear_in) begin
         busy_q      <= '0;
         cdb_valid_q <= 1'b0;
      end else if (rdy_in) begin
         busy_q      <= busy_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
         cdb_topc_q  <= cdb_topc_d;
      end
   end

   // NOTE: entry payload is deliberately not reset; it is only observed while its busy bit is set.
   always_ff @(posedge clk_in) begin
      if (rdy_in)
         ent_q <= ent_d;
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag   = cdb_tag_q;
   assign cdb_value = cdb_value_q;
   assign cdb_topc  = cdb_topc_q;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: vector table for single-op issue plus hand sequences for
// wakeup, bypass, full, back-to-back, flush and stall behaviour.
module tb_rs_alu;

   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_ADDI = 6'd3;
   localparam logic [5:0] OP_JALR = 6'd4;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, clear_in;
   logic        disp_valid, disp_qj_busy, disp_qk_busy;
   logic [5:0]  disp_order;
   logic [31:0] disp_vj, disp_vk, disp_A, disp_pc;
   logic [3:0]  disp_qj, disp_qk, disp_tag;
   logic        full;
   logic        lsb_cdb_valid;
   logic [3:0]  lsb_cdb_tag;
   logic [31:0] lsb_cdb_value;
   logic [5:0]  ex_order;
   logic [31:0] ex_vj, ex_vk, ex_A, ex_pc, ex_value, ex_topc;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value, cdb_topc;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk_in = ~clk_in;

   rs_alu dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
      .disp_valid(disp_valid), .disp_order(disp_order), .disp_vj(disp_vj),
      .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_vk(disp_vk),
      .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk), .disp_A(disp_A), .disp_pc(disp_pc),
      .disp_tag(disp_tag), .full(full), .lsb_cdb_valid(lsb_cdb_valid),
      .lsb_cdb_tag(lsb_cdb_tag), .lsb_cdb_value(lsb_cdb_value), .ex_order(ex_order),
      .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_A(ex_A), .ex_pc(ex_pc), .ex_value(ex_value),
      .ex_topc(ex_topc), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_topc(cdb_topc)
   );

   // Minimal EX unit for the op codes used here.
   always_comb begin
      ex_value = '0;
      ex_topc  = '0;
      case (ex_order)
         OP_ADD:  ex_value = ex_vj + ex_vk;
         OP_SUB:  ex_value = ex_vj - ex_vk;
         OP_ADDI: ex_value = ex_vj + ex_A;
         OP_JALR: begin
            ex_value = ex_pc + 32'd4;
            ex_topc  = (ex_vj + ex_A) & ~32'd1;
         end
         default: ;
      endcase
   end

   typedef struct {
      logic [5:0]  order;
      logic [31:0] vj, vk, a, pc;
      logic [3:0]  tag;
      logic [31:0] exp_value, exp_topc;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic dispatch(input logic [5:0] order, input logic [31:0] vj, input logic qjb,
                           input logic [3:0] qj, input logic [31:0] vk, input logic qkb,
                           input logic [3:0] qk, input logic [31:0] a, input logic [31:0] pc,
                           input logic [3:0] tag);
      disp_valid   = 1'b1;
      disp_order   = order;
      disp_vj      = vj;
      disp_qj_busy = qjb;
      disp_qj      = qj;
      disp_vk      = vk;
      disp_qk_busy = qkb;
      disp_qk      = qk;
      disp_A       = a;
      disp_pc      = pc;
      disp_tag     = tag;
   endtask

   task automatic lsb(input logic v, input logic [3:0] tag, input logic [31:0] value);
      lsb_cdb_valid = v;
      lsb_cdb_tag   = tag;
      lsb_cdb_value = value;
   endtask

   initial begin
      vecs[0] = '{OP_ADD,  32'd5,          32'd7,  32'd0, 32'h10,  4'd3, 32'd12,    32'd0};
      vecs[1] = '{OP_SUB,  32'd100,        32'd58, 32'd0, 32'h20,  4'd7, 32'd42,    32'd0};
      vecs[2] = '{OP_ADDI, 32'hFFFF_FFFF,  32'd0,  32'd2, 32'h30,  4'd0, 32'd1,     32'd0};
      vecs[3] = '{OP_JALR, 32'h1001,       32'd0,  32'd4, 32'h100, 4'd2, 32'h104,   32'h1004};

      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
      dispatch(6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      disp_valid = 1'b0;
      lsb(1'b0, 4'd0, 32'd0);
      tick(); tick();
      rst_in = 1'b0;

      check("reset full", {31'd0, full}, 32'd0);
      check("reset cdb_valid", {31'd0, cdb_valid}, 32'd0);
      check("reset cdb_tag", {28'd0, cdb_tag}, 32'd0);
      check("reset cdb_value", cdb_value, 32'd0);
      check("reset cdb_topc", cdb_topc, 32'd0);
      check("reset ex_order", {26'd0, ex_order}, 32'd0);

      // Single ready ops: issue the cycle after dispatch, result on the CDB one cycle later.
      for (int v = 0; v < 4; v++) begin
         dispatch(vecs[v].order, vecs[v].vj, 0, 0, vecs[v].vk, 0, 0, vecs[v].a, vecs[v].pc,
                  vecs[v].tag);
         tick();
         disp_valid = 1'b0;
         check($sformatf("vec%0d ex_order", v), {26'd0, ex_order}, {26'd0, vecs[v].order});
         check($sformatf("vec%0d ex_pc", v), ex_pc, vecs[v].pc);
         check($sformatf("vec%0d cdb_valid early", v), {31'd0, cdb_valid}, 32'd0);
         tick();
         check($sformatf("vec%0d cdb_valid", v), {31'd0, cdb_valid}, 32'd1);
         check($sformatf("vec%0d cdb_tag", v), {28'd0, cdb_tag}, {28'd0, vecs[v].tag});
         check($sformatf("vec%0d cdb_value", v), cdb_value, vecs[v].exp_value);
         check($sformatf("vec%0d cdb_topc", v), cdb_topc, vecs[v].exp_topc);
         check($sformatf("vec%0d ex idle", v), {26'd0, ex_order}, 32'd0);
      end

      // LSB wakeup: SUB waits on tag 6, no issue until the wakeup edge.
      dispatch(OP_SUB, 32'd0, 1, 4'd6, 32'd4, 0, 0, 0, 32'h40, 4'd1);
      tick();
      disp_valid = 1'b0;
      check("wake pending 0", {26'd0, ex_order}, 32'd0);
      tick();
      check("wake idle cdb", {31'd0, cdb_valid}, 32'd0);
      tick();
      lsb(1'b1, 4'd6, 32'd20);
      check("wake pending 2", {26'd0, ex_order}, 32'd0);
      tick();
      lsb(1'b0, 4'd0, 32'd0);
      check("wake ex_order", {26'd0, ex_order}, {26'd0, OP_SUB});
      check("wake ex_vj", ex_vj, 32'd20);
      check("wake cdb not yet", {31'd0, cdb_valid}, 32'd0);
      tick();
      check("wake cdb_valid", {31'd0, cdb_valid}, 32'd1);
      check("wake cdb_tag", {28'd0, cdb_tag}, 32'd1);
      check("wake cdb_value", cdb_value, 32'd16);

      // Fill all eight slots waiting on tag 9, then drain in index order.
      for (int i = 0; i < 8; i++) begin
         dispatch(OP_ADD, 32'd0, 1, 4'd9, i, 0, 0, 0, 32'h200, 4'(i));
         tick();
      end
      check("full set", {31'd0, full}, 32'd1);
      dispatch(OP_ADD, 32'd1, 0, 0, 32'd1, 0, 0, 0, 32'h300, 4'd15);
      tick();
      disp_valid = 1'b0;
      check("full ignored dispatch", {31'd0, full}, 32'd1);
      check("full ignored no issue", {26'd0, ex_order}, 32'd0);
      lsb(1'b1, 4'd9, 32'd100);
      tick();
      lsb(1'b0, 4'd0, 32'd0);
      check("drain first ex_vk", ex_vk, 32'd0);
      check("drain first ex_vj", ex_vj, 32'd100);
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 0) check("full drops", {31'd0, full}, 32'd0);
         check($sformatf("drain%0d cdb_valid", k), {31'd0, cdb_valid}, 32'd1);
         check($sformatf("drain%0d cdb_tag", k), {28'd0, cdb_tag}, k);
         check($sformatf("drain%0d cdb_value", k), cdb_value, 32'd100 + k);
      end
      tick();
      check("drain done", {31'd0, cdb_valid}, 32'd0);

      // Back-to-back: ADDI tag 4 (=10) feeds ADD tag 5 via the own CDB.
      dispatch(OP_ADDI, 32'd7, 0, 0, 32'd0, 0, 0, 32'd3, 32'h400, 4'd4);
      tick();
      dispatch(OP_ADD, 32'd0, 1, 4'd4, 32'd1, 0, 0, 0, 32'h404, 4'd5);
      check("b2b N ex_order", {26'd0, ex_order}, {26'd0, OP_ADDI});
      tick();
      disp_valid = 1'b0;
      check("b2b N+1 cdb_tag", {28'd0, cdb_tag}, 32'd4);
      check("b2b N+1 cdb_value", cdb_value, 32'd10);
      check("b2b N+1 dep waiting", {26'd0, ex_order}, 32'd0);
      tick();
      check("b2b N+2 cdb_valid", {31'd0, cdb_valid}, 32'd0);
      check("b2b N+2 ex_vj", ex_vj, 32'd10);
      tick();
      check("b2b N+3 cdb_valid", {31'd0, cdb_valid}, 32'd1);
      check("b2b N+3 cdb_tag", {28'd0, cdb_tag}, 32'd5);
      check("b2b N+3 cdb_value", cdb_value, 32'd11);

      // Dispatch bypass from the LSB bus, then from the own CDB.
      dispatch(OP_SUB, 32'd10, 0, 0, 32'd0, 1, 4'd11, 0, 32'h500, 4'd6);
      lsb(1'b1, 4'd11, 32'd3);
      tick();
      lsb(1'b0, 4'd0, 32'd0);
      disp_valid = 1'b0;
      check("lsb bypass ex_vk", ex_vk, 32'd3);
      tick();
      check("lsb bypass cdb_value", cdb_value, 32'd7);
      dispatch(OP_ADD, 32'd0, 1, 4'd6, 32'd5, 0, 0, 0, 32'h504, 4'd7);
      tick();
      disp_valid = 1'b0;
      check("cdb bypass ex_vj", ex_vj, 32'd7);
      tick();
      check("cdb bypass cdb_tag", {28'd0, cdb_tag}, 32'd7);
      check("cdb bypass cdb_value", cdb_value, 32'd12);

      // Flush with a waiting entry, an issuing entry and a same-cycle dispatch.
      dispatch(OP_ADD, 32'd0, 1, 4'd12, 32'd1, 0, 0, 0, 32'h600, 4'd8);
      tick();
      dispatch(OP_ADD, 32'd1, 0, 0, 32'd1, 0, 0, 0, 32'h604, 4'd9);
      tick();
      dispatch(OP_ADD, 32'd2, 0, 0, 32'd2, 0, 0, 0, 32'h608, 4'd10);
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      disp_valid = 1'b0;
      check("clear cdb_valid", {31'd0, cdb_valid}, 32'd0);
      check("clear full", {31'd0, full}, 32'd0);
      check("clear no candidate", {26'd0, ex_order}, 32'd0);
      lsb(1'b1, 4'd12, 32'd50);
      tick();
      lsb(1'b0, 4'd0, 32'd0);
      check("clear no wake", {26'd0, ex_order}, 32'd0);
      tick();
      check("clear no later issue", {31'd0, cdb_valid}, 32'd0);

      // Stall: cdb and entries hold, dispatch and wakeups ignored while rdy_in is low.
      dispatch(OP_ADD, 32'd0, 1, 4'd14, 32'd1, 0, 0, 0, 32'h700, 4'd11);
      tick();
      dispatch(OP_ADD, 32'd2, 0, 0, 32'd3, 0, 0, 0, 32'h704, 4'd13);
      tick();
      disp_valid = 1'b0;
      check("stall pre ex_vj", ex_vj, 32'd2);
      tick();
      check("stall pre cdb_value", cdb_value, 32'd5);
      rdy_in = 1'b0;
      dispatch(OP_ADD, 32'd1, 0, 0, 32'd1, 0, 0, 0, 32'h708, 4'd15);
      lsb(1'b1, 4'd14, 32'd7);
      for (int s = 0; s < 3; s++) begin
         tick();
         check($sformatf("stall%0d cdb_valid", s), {31'd0, cdb_valid}, 32'd1);
         check($sformatf("stall%0d cdb_tag", s), {28'd0, cdb_tag}, 32'd13);
         check($sformatf("stall%0d no candidate", s), {26'd0, ex_order}, 32'd0);
      end
      rdy_in = 1'b1;
      disp_valid = 1'b0;
      lsb(1'b0, 4'd0, 32'd0);
      tick();
      check("resume cdb_valid", {31'd0, cdb_valid}, 32'd0);
      check("resume still waiting", {26'd0, ex_order}, 32'd0);
      lsb(1'b1, 4'd14, 32'd7);
      tick();
      lsb(1'b0, 4'd0, 32'd0);
      check("resume wake ex_vj", ex_vj, 32'd7);
      tick();
      check("resume cdb_tag", {28'd0, cdb_tag}, 32'd11);
      check("resume cdb_value", cdb_value, 32'd8);
      tick();
      check("resume stall dispatch dropped", {31'd0, cdb_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
